// File: rtl/dmux_sync_pkg.sv
// Shared constants and helpers for the multi-channel receive synchronizer.
package dmux_sync_pkg;

  localparam logic MODE_EDGE    = 1'b0;
  localparam logic MODE_TOGGLE  = 1'b1;
  localparam int   MAX_CHANNELS = 16;

  // Channel-index width; never zero so a single-channel build still has a port.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dmux_sync_chan.sv
// One receive channel: request synchronizer, event detect, hold register, pending/overflow state, ack toggle.
// Capture lands one cycle after the event is seen at the end of the sync chain.
module dmux_sync_chan
  import dmux_sync_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk_b,
  input  logic             i_rst_b,
  input  logic             i_en,
  input  logic             i_mode,
  input  logic             i_req_async,
  input  logic [WIDTH-1:0] i_data_in,
  input  logic             i_grant,
  input  logic             i_ovf_clr,
  output logic             o_pending,
  output logic [WIDTH-1:0] o_hold,
  output logic             o_ack_tgl,
  output logic             o_ovf
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_pending;
  logic [WIDTH-1:0]       r_hold;
  logic                   r_ack;
  logic                   r_ovf;

  logic w_last;
  logic w_evt;
  logic w_cap;
  logic w_drop;

  assign w_last = r_sync[SYNC_STAGES-1];
  assign w_evt  = i_en & ((i_mode == MODE_TOGGLE) ? (w_last ^ r_prev) : (w_last & ~r_prev));
  // A granted channel frees its hold slot this cycle, so a simultaneous event may reuse it.
  assign w_cap  = w_evt & (~r_pending | i_grant);
  assign w_drop = w_evt & r_pending & ~i_grant;

  always_ff @(posedge i_clk_b) begin
    if (i_rst_b) begin
      r_sync    <= '0;
      r_prev    <= 1'b0;
      r_pending <= 1'b0;
      r_hold    <= '0;
      r_ack     <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (i_en) begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], i_req_async};
        r_prev <= w_last;
      end
      if (w_cap) begin
        r_hold    <= i_data_in;
        r_pending <= 1'b1;
      end else if (i_grant) begin
        r_pending <= 1'b0;
      end
      if (i_grant) begin
        r_ack <= ~r_ack;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (i_ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign o_pending = r_pending;
  assign o_hold    = r_hold;
  assign o_ack_tgl = r_ack;
  assign o_ovf     = r_ovf;

endmodule

// File: rtl/dmux_sync_rx_mc.sv
// Multi-channel CDC receive side: per-channel sync/capture merged round-robin onto one valid/ready stream.
// Request edge to vld_out is SYNC_STAGES+2 clk_b edges; rdy_in low holds data_out/ch_out stable.
module dmux_sync_rx_mc
  import dmux_sync_pkg::*;
#(
  parameter  int WIDTH       = 32,
  parameter  int CHANNELS    = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int CH_W        = clog2_min1(CHANNELS)
) (
  input  logic                      clk_b,
  input  logic                      rst_b,
  input  logic                      dmux_en,
  input  logic                      sync_mode,
  input  logic [CHANNELS-1:0]       req_async,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  output logic [CHANNELS-1:0]       ack_tgl,
  output logic                      vld_out,
  input  logic                      rdy_in,
  output logic [WIDTH-1:0]          data_out,
  output logic [CH_W-1:0]           ch_out,
  output logic [CHANNELS-1:0]       ovf,
  input  logic                      ovf_clr
);

  logic [CHANNELS-1:0] w_pending;
  logic [WIDTH-1:0]    w_hold [CHANNELS];
  logic [CHANNELS-1:0] w_grant;
  logic                w_take;
  logic                w_found;
  logic [CH_W-1:0]     w_gidx;
  logic [CH_W:0]       w_idx;

  logic                r_vld;
  logic [WIDTH-1:0]    r_data;
  logic [CH_W-1:0]     r_ch;
  logic [CH_W-1:0]     r_rr_ptr;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    dmux_sync_chan #(
      .WIDTH      (WIDTH),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_chan (
      .i_clk_b    (clk_b),
      .i_rst_b    (rst_b),
      .i_en       (dmux_en),
      .i_mode     (sync_mode),
      .i_req_async(req_async[c]),
      .i_data_in  (data_in[c*WIDTH +: WIDTH]),
      .i_grant    (w_grant[c]),
      .i_ovf_clr  (ovf_clr),
      .o_pending  (w_pending[c]),
      .o_hold     (w_hold[c]),
      .o_ack_tgl  (ack_tgl[c]),
      .o_ovf      (ovf[c])
    );
  end

  // Output slot is free when empty or being consumed this cycle.
  assign w_take = ~r_vld | rdy_in;

  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_idx   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_idx = {1'b0, r_rr_ptr} + (CH_W+1)'(i);
      if (w_idx >= (CH_W+1)'(CHANNELS)) begin
        w_idx = w_idx - (CH_W+1)'(CHANNELS);
      end
      if (!w_found && w_pending[w_idx[CH_W-1:0]]) begin
        w_found = 1'b1;
        w_gidx  = w_idx[CH_W-1:0];
      end
    end
  end

  always_comb begin
    w_grant = '0;
    if (w_take && w_found) begin
      w_grant[w_gidx] = 1'b1;
    end
  end

  always_ff @(posedge clk_b) begin
    if (rst_b) begin
      r_vld    <= 1'b0;
      r_data   <= '0;
      r_ch     <= '0;
      r_rr_ptr <= '0;
    end else if (w_take) begin
      if (w_found) begin
        r_vld    <= 1'b1;
        r_data   <= w_hold[w_gidx];
        r_ch     <= w_gidx;
        r_rr_ptr <= (w_gidx == CH_W'(CHANNELS-1)) ? '0 : w_gidx + CH_W'(1);
      end else begin
        r_vld <= 1'b0;
      end
    end
  end

  assign vld_out  = r_vld;
  assign data_out = r_data;
  assign ch_out   = r_ch;

endmodule

// File: tb/tb_dmux_sync_rx_mc.sv
// Directed scenarios followed by a randomized toggle-protocol run checked against per-channel expected queues.
module tb_dmux_sync_rx_mc;

  localparam int W = 32;
  localparam int C = 4;
  localparam int S = 2;
  localparam int LAT = S + 2;

  logic           clk_b = 1'b0;
  logic           rst_b;
  logic           dmux_en;
  logic           sync_mode;
  logic [C-1:0]   req_async;
  logic [C*W-1:0] data_in;
  logic [C-1:0]   ack_tgl;
  logic           vld_out;
  logic           rdy_in;
  logic [W-1:0]   data_out;
  logic [1:0]     ch_out;
  logic [C-1:0]   ovf;
  logic           ovf_clr;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q [C][$];

  always #5 clk_b = ~clk_b;

  dmux_sync_rx_mc #(.WIDTH(W), .CHANNELS(C), .SYNC_STAGES(S)) dut (
    .clk_b    (clk_b),
    .rst_b    (rst_b),
    .dmux_en  (dmux_en),
    .sync_mode(sync_mode),
    .req_async(req_async),
    .data_in  (data_in),
    .ack_tgl  (ack_tgl),
    .vld_out  (vld_out),
    .rdy_in   (rdy_in),
    .data_out (data_out),
    .ch_out   (ch_out),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  task automatic tick();
    @(posedge clk_b);
    @(negedge clk_b);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic mode);
    rst_b     = 1'b1;
    req_async = '0;
    sync_mode = mode;
    dmux_en   = 1'b1;
    ovf_clr   = 1'b0;
    ticks(2);
    rst_b = 1'b0;
  endtask

  task automatic send(input int c, input logic [W-1:0] d);
    data_in[c*W +: W] = d;
    req_async[c]      = ~req_async[c];
  endtask

  task automatic expect_word(input string tag, input int c, input logic [W-1:0] d);
    chk({tag, "_vld"}, vld_out, 1);
    chk({tag, "_ch"}, ch_out, c);
    chk({tag, "_data"}, data_out, d);
  endtask

  initial begin
    rst_b = 1'b1; dmux_en = 1'b1; sync_mode = 1'b1; req_async = '0;
    data_in = '0; rdy_in = 1'b1; ovf_clr = 1'b0;
    @(negedge clk_b);
    do_reset(1'b1);
    chk("rst_vld", vld_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_ch", ch_out, 0);
    chk("rst_ack", ack_tgl, 0);
    chk("rst_ovf", ovf, 0);

    // Toggle-mode single request: SYNC_STAGES+2 edges to vld_out.
    send(1, 32'hA5A5_0001);
    ticks(LAT - 1);
    chk("t1_early", vld_out, 0);
    tick();
    expect_word("t1", 1, 32'hA5A5_0001);
    chk("t1_ack", ack_tgl, 4'b0010);
    tick();
    chk("t1_idle", vld_out, 0);

    // Edge mode: three simultaneous rising requests drain in round-robin order.
    do_reset(1'b0);
    data_in[0*W +: W] = 32'h1111_0000;
    data_in[2*W +: W] = 32'h2222_0002;
    data_in[3*W +: W] = 32'h3333_0003;
    req_async = 4'b1101;
    ticks(LAT);
    expect_word("t2_w0", 0, 32'h1111_0000);
    tick();
    expect_word("t2_w1", 2, 32'h2222_0002);
    tick();
    expect_word("t2_w2", 3, 32'h3333_0003);
    tick();
    chk("t2_idle", vld_out, 0);
    req_async = 4'b0000;
    ticks(LAT + 2);
    chk("t2_fall_noevt", vld_out, 0);

    // Backpressure: held word stays stable, second channel not acked until granted.
    do_reset(1'b1);
    rdy_in = 1'b0;
    send(1, 32'hBEEF_0001);
    send(3, 32'hBEEF_0003);
    ticks(LAT);
    for (int i = 0; i < 4; i++) begin
      expect_word("t3_hold", 1, 32'hBEEF_0001);
      chk("t3_ack", ack_tgl, 4'b0010);
      tick();
    end
    rdy_in = 1'b1;
    tick();
    expect_word("t3_next", 3, 32'hBEEF_0003);
    chk("t3_ack2", ack_tgl, 4'b1010);
    tick();
    chk("t3_idle", vld_out, 0);

    // Overflow: ch2 re-requests while pending behind a stalled ch0 word.
    rdy_in = 1'b0;
    send(0, 32'hC0C0_0000);
    send(2, 32'hC2C2_0001);
    ticks(LAT);
    expect_word("t4_first", 0, 32'hC0C0_0000);
    send(2, 32'hDEAD_0002);
    ticks(LAT);
    chk("t4_ovf", ovf, 4'b0100);
    rdy_in = 1'b1;
    tick();
    expect_word("t4_kept", 2, 32'hC2C2_0001);
    tick();
    chk("t4_dropped", vld_out, 0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t4_clr", ovf, 0);

    // Disabled block: toggle is deferred until re-enable.
    do_reset(1'b1);
    dmux_en = 1'b0;
    send(3, 32'h5555_0003);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5_frozen", vld_out, 0);
    end
    dmux_en = 1'b1;
    ticks(LAT - 1);
    chk("t5_early", vld_out, 0);
    tick();
    expect_word("t5_deferred", 3, 32'h5555_0003);

    // Edge-mode pulse wholly inside the disabled window is lost.
    do_reset(1'b0);
    dmux_en = 1'b0;
    tick();
    req_async[0] = 1'b1;
    ticks(2);
    req_async[0] = 1'b0;
    tick();
    dmux_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t5_pulse_lost", vld_out, 0);
    end

    // Reset with work in flight clears everything; arbitration restarts at ch0.
    do_reset(1'b1);
    rdy_in = 1'b0;
    for (int c = 0; c < C; c++) send(c, 32'h7000_0000 + c);
    ticks(LAT);
    expect_word("t6_pre", 0, 32'h7000_0000);
    rst_b     = 1'b1;
    req_async = '0;
    tick();
    chk("t6_vld", vld_out, 0);
    chk("t6_data", data_out, 0);
    chk("t6_ch", ch_out, 0);
    chk("t6_ack", ack_tgl, 0);
    rst_b  = 1'b0;
    rdy_in = 1'b1;
    ticks(LAT + 2);
    chk("t6_no_stale", vld_out, 0);
    send(2, 32'h8000_0002);
    send(0, 32'h8000_0000);
    ticks(LAT);
    expect_word("t6_first", 0, 32'h8000_0000);
    tick();
    expect_word("t6_second", 2, 32'h8000_0002);

    // Random traffic: sources obey the toggle handshake, sink applies random backpressure.
    do_reset(1'b1);
    for (int cyc = 0; cyc < 900; cyc++) begin
      rdy_in = ($urandom_range(0, 3) != 0);
      if (vld_out && rdy_in) begin
        if (int'(ch_out) >= C || exp_q[ch_out].size() == 0) begin
          chk("rand_unexpected_word", 1, 0);
        end else begin
          chk("rand_data", data_out, exp_q[ch_out].pop_front());
        end
      end
      if (cyc < 750) begin
        for (int c = 0; c < C; c++) begin
          if (ack_tgl[c] == req_async[c] && $urandom_range(0, 2) == 0) begin
            logic [W-1:0] d;
            d = $urandom;
            send(c, d);
            exp_q[c].push_back(d);
          end
        end
      end
      tick();
    end
    for (int c = 0; c < C; c++) chk("rand_drained", exp_q[c].size(), 0);
    chk("rand_no_ovf", ovf, 0);
    chk("rand_idle", vld_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
